// File: rtl/col_tx.sv
// Column transmitter: packs a valid/ready stream of 2-bit symbols into one COLS-wide beat
// and emits it as a single-cycle per-column valid mask with matching data.
module col_tx #(
    parameter int unsigned COLS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_data,
    input  logic                 in_last,
    input  logic                 hold,
    output logic [COLS-1:0]      oval,
    output logic [COLS-1:0][1:0] odata,
    output logic [15:0]          beat_cnt
);

    localparam int unsigned PtrW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [PtrW-1:0] PtrMax = PtrW'(COLS - 1);

    typedef enum logic [0:0] {StFill, StEmit} state_e;

    state_e               state_q, state_d;
    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [COLS-1:0][1:0] acc_q, acc_d;
    logic [COLS-1:0]      mask_q, mask_d;
    logic [COLS-1:0]      oval_q, oval_d;
    logic [COLS-1:0][1:0] odata_q, odata_d;
    logic [15:0]          beat_cnt_q, beat_cnt_d;
    logic                 accept;

    assign in_ready = (state_q == StFill) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        acc_d      = acc_q;
        mask_d     = mask_q;
        oval_d     = '0;
        odata_d    = odata_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    for (int unsigned i = 0; i < COLS; i++) begin
                        if (PtrW'(i) == ptr_q) begin
                            acc_d[i]  = in_data;
                            mask_d[i] = 1'b1;
                        end
                    end
                    if (ptr_q == PtrMax || in_last) begin
                        ptr_d   = '0;
                        state_d = StEmit;
                    end else begin
                        ptr_d = ptr_q + PtrW'(1);
                    end
                end
            end
            StEmit: begin
                if (!hold) begin
                    oval_d = mask_q;
                    // acc is never cleared, so stale columns of a partial beat are masked here
                    for (int unsigned i = 0; i < COLS; i++) begin
                        odata_d[i] = mask_q[i] ? acc_q[i] : 2'b00;
                    end
                    mask_d     = '0;
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    state_d    = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFill;
            ptr_q      <= '0;
            acc_q      <= '0;
            mask_q     <= '0;
            oval_q     <= '0;
            odata_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            acc_q      <= acc_d;
            mask_q     <= mask_d;
            oval_q     <= oval_d;
            odata_q    <= odata_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign oval     = oval_q;
    assign odata    = odata_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_col_tx.sv
// Directed bench for col_tx: a COLS=4 instance for beat packing, hold, reset and stalls,
// and a COLS=1 instance for single-column beats and the beat counter wrap.
module tb_col_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last, hold, in_ready;
    logic [1:0] in_data;
    logic [3:0] oval;
    logic [3:0][1:0] odata;
    logic [15:0] beat_cnt;

    logic       v1, l1, h1, ready1;
    logic [1:0] d1;
    logic [0:0] oval1;
    logic [0:0][1:0] odata1;
    logic [15:0] beat_cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    col_tx #(.COLS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .hold     (hold),
        .oval     (oval),
        .odata    (odata),
        .beat_cnt (beat_cnt)
    );

    col_tx #(.COLS(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (v1),
        .in_ready (ready1),
        .in_data  (d1),
        .in_last  (l1),
        .hold     (h1),
        .oval     (oval1),
        .odata    (odata1),
        .beat_cnt (beat_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] q_m[$];
    logic [7:0] q_d[$];
    logic [3:0] cm, prev_oval;
    logic [7:0] cd;
    int         cnt, sent_beats;
    logic       pending, took;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 2'd0; in_last = 1'b0; hold = 1'b0;
        v1 = 1'b0; d1 = 2'd0; l1 = 1'b0; h1 = 1'b0;
        #1;
        check("rst_ready", in_ready, 0);
        tick(); tick();
        check("rst_oval", oval, 0);
        check("rst_odata", odata, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);

        // Full beat: 1,2,3,0
        in_valid = 1'b1; in_data = 2'd1; tick();
        in_data = 2'd2; tick();
        in_data = 2'd3; tick();
        in_data = 2'd0; tick();
        in_valid = 1'b0;
        check("full_emit_ready", in_ready, 0);
        check("full_oval_early", oval, 0);
        tick();
        check("full_oval", oval, 4'hF);
        check("full_odata", odata, 8'h39);
        check("full_beat_cnt", beat_cnt, 1);
        check("full_ready_back", in_ready, 1);
        tick();
        check("full_oval_pulse", oval, 0);
        check("full_odata_hold", odata, 8'h39);

        // Partial beat: 2 then 1 with last
        in_valid = 1'b1; in_data = 2'd2; tick();
        in_data = 2'd1; in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        check("part_oval", oval, 4'b0011);
        check("part_odata", odata, 8'h06);
        check("part_beat_cnt", beat_cnt, 2);

        // Hold: beat 2,1,0,3 (also shows restart at column 0), hold 5 cycles
        in_valid = 1'b1; in_data = 2'd2; tick();
        in_data = 2'd1; tick();
        in_data = 2'd0; tick();
        in_data = 2'd3; hold = 1'b1; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_oval", oval, 0);
            check("hold_ready", in_ready, 0);
        end
        hold = 1'b0;
        tick();
        check("hold_oval_rel", oval, 4'hF);
        check("hold_odata", odata, 8'hC6);
        check("hold_beat_cnt", beat_cnt, 3);
        tick();
        check("hold_oval_pulse", oval, 0);

        // Reset mid-beat, with in_valid asserted during the reset cycle
        in_valid = 1'b1; in_data = 2'd1; tick(); tick(); tick();
        rst = 1'b1; in_data = 2'd3;
        #1;
        check("midrst_ready", in_ready, 0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_beat_cnt", beat_cnt, 0);
        check("midrst_odata", odata, 0);
        in_valid = 1'b1; in_data = 2'd0; tick();
        in_data = 2'd1; tick();
        in_data = 2'd2; tick();
        in_data = 2'd3; tick();
        in_valid = 1'b0;
        tick();
        check("midrst_oval", oval, 4'hF);
        check("midrst_odata_fresh", odata, 8'hE4);
        check("midrst_beat_cnt1", beat_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_extra", oval, 0);
        end

        // Source stalls with random partial beats, checked against a stream scoreboard
        cnt = 0; sent_beats = 0; cm = '0; cd = '0; pending = 1'b0; in_valid = 1'b0;
        for (int cyc = 0; cyc < 5000 && (sent_beats < 100 || q_m.size() > 0); cyc++) begin
            if (!pending) begin
                if (sent_beats < 100 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = 2'($urandom_range(0, 3));
                    in_last  = ($urandom_range(0, 4) == 0);
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
            end
            #1;
            took = in_valid && in_ready;
            if (took) begin
                cm[cnt] = 1'b1;
                cd[cnt*2 +: 2] = in_data;
                if (cnt == 3 || in_last) begin
                    q_m.push_back(cm);
                    q_d.push_back(cd);
                    sent_beats++;
                    cnt = 0; cm = '0; cd = '0;
                end else begin
                    cnt++;
                end
            end
            pending = in_valid && !took;
            prev_oval = oval;
            tick();
            if (oval != 0) begin
                check("stall_pulse_len", prev_oval, 0);
                if (q_m.size() == 0) begin
                    check("stall_unexpected_beat", oval, 0);
                end else begin
                    check("stall_oval", oval, q_m.pop_front());
                    check("stall_odata", odata, q_d.pop_front());
                end
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("stall_drained", q_m.size(), 0);
        check("stall_sent", sent_beats, 100);
        check("stall_beat_cnt", beat_cnt, 101);

        // Single column: symbols 2,3,1 held valid through EMIT
        v1 = 1'b1; d1 = 2'd2; tick();
        check("c1_emit_ready", ready1, 0);
        check("c1_oval_early", oval1, 0);
        d1 = 2'd3; tick();
        check("c1_oval_a", oval1, 1);
        check("c1_odata_a", odata1, 2);
        check("c1_ready_back", ready1, 1);
        tick();
        check("c1_oval_gap", oval1, 0);
        d1 = 2'd1; tick();
        check("c1_oval_b", oval1, 1);
        check("c1_odata_b", odata1, 3);
        tick();
        v1 = 1'b0;
        check("c1_oval_gap2", oval1, 0);
        tick();
        check("c1_oval_c", oval1, 1);
        check("c1_odata_c", odata1, 1);
        check("c1_beat_cnt", beat_cnt1, 3);

        // Beat counter wrap: 65532 more single-column beats reach 16'hFFFF, one more wraps
        v1 = 1'b1; d1 = 2'd2;
        for (int i = 0; i < 65532; i++) begin
            tick(); tick();
        end
        check("wrap_max", beat_cnt1, 16'hFFFF);
        tick(); tick();
        check("wrap_zero", beat_cnt1, 0);
        check("wrap_oval", oval1, 1);
        v1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/col_tx.md
# col_tx

Column transmitter: the sending end of the per-column `ival`/`idata` bus that the column-array top consumes. It accepts a serial stream of 2-bit symbols over a valid/ready handshake, packs them into one COLS-wide beat (symbol 0 to column 0), and emits the beat as a one-cycle `oval` mask with matching `odata`. It sits directly upstream of the column receiver. The output side has no backpressure; a `hold` input defers emission instead.

## Interface

- `COLS`, default 4: number of columns per beat; legal range ≥ 1.
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `in_valid`: input, 1 bit. Input symbol valid.
- `in_ready`: output, 1 bit. Block can accept a symbol.
- `in_data`: input, 2 bits. Symbol to place in the next free column.
- `in_last`: input, 1 bit. Closes the current beat early (partial beat). Qualified by the handshake.
- `hold`: input, 1 bit. Downstream busy; defers emission while high.
- `oval`: output, `[COLS-1:0]`. Per-column valid. Registered; high for exactly one cycle per beat.
- `odata`: output, `[COLS-1:0][1:0]`. Per-column data. Registered; updated only on emission.
- `beat_cnt`: output, 16 bits. Count of emitted beats; wraps 16'hFFFF → 0.

## Operation

- **State machine:** two states, FILL and EMIT. Internal state is:
  - column pointer `ptr`, width `$clog2(COLS)` with a minimum of 1;
  - accumulator `acc [COLS-1:0][1:0]`;
  - fill mask `mask [COLS-1:0]`.
- **`in_ready`:** combinational, equal to `(state==FILL) && !rst`.
- **Accept:** occurs when `in_valid && in_ready`. On accept:
  - `acc[ptr] <= in_data` and `mask[ptr] <= 1`.
  - If `ptr==COLS-1` or `in_last`: `ptr <= 0` and the state goes to EMIT.
  - Otherwise `ptr <= ptr+1`.
- **FILL:** `hold` has no effect in this state.
- **EMIT, `hold` low:** on the clock edge:
  - `oval <= mask` and `odata <= acc`;
  - columns with a 0 mask bit drive `odata` 2'b00;
  - `mask <= 0`, `beat_cnt <= beat_cnt+1`, and the state goes to FILL.
- **EMIT, `hold` high:** the block stays in EMIT. `in_ready` stays 0 and `acc`/`mask` are unchanged.
- **`oval` outside emission:** every cycle without an emission edge, `oval <= 0`. `odata` holds its last emitted value.
- **Full beat:** a full beat has `oval` all-ones. A partial beat from `in_last` has `oval` as a contiguous mask from column 0 (e.g. 4'b0011 after two symbols).
- **`in_last` on the first symbol:** `in_last` on the first symbol of a beat emits a single-column beat.
- **`COLS==1`:** every accepted symbol produces a beat.
- **Reset:** `rst` high forces:
  - state FILL, `ptr` 0, `mask` 0, `acc` 0;
  - `oval` 0, `odata` 0, `beat_cnt` 0.

  A partially filled or held beat is discarded and never emitted. `in_ready` is 0 during the reset cycle.

## Timing

- **Emission latency:** the symbol that completes a beat is accepted at edge N. EMIT occupies cycle N..N+1. `oval` is visible from edge N+1 to N+2 when `hold` is low in that cycle.
- **`hold` delay:** each cycle of `hold` high in EMIT delays `oval` by one cycle.
- **Throughput:** one full beat per COLS+1 cycles at best, i.e. COLS accepts plus one EMIT cycle in which `in_ready` is 0.
- **`in_ready` in EMIT:** `in_ready` is low for the whole of EMIT, including the first EMIT cycle. Symbols presented then are not accepted and must be held by the source.
- **`rst` and `in_valid` together:** `rst` asserted in the same cycle as `in_valid` means no accept.
- **`beat_cnt`:** updates on the same edge that loads `oval`.

## Test plan

- **Full beat:** reset, then stream symbols 1,2,3,0 back-to-back with `hold`=0 and COLS=4.
  - Required: one cycle of `oval`=4'b1111 with `odata` = {0,3,2,1} (col3..col0), two edges after the 4th accept.
  - Required: `in_ready` low for exactly one cycle; `beat_cnt`=1.
- **Partial beat:** send 2'b10 then 2'b01 with `in_last` on the second.
  - Required: `oval`=4'b0011, `odata` col0=2, col1=1, col2=col3=0.
  - Required: the next beat starts at column 0.
- **Hold:** complete a beat, then keep `hold`=1 for 5 cycles.
  - Required: `oval` stays 0 and `in_ready` stays 0 for those 5 cycles.
  - Required: `oval` pulses one cycle after `hold` drops, with the correct data.
- **Reset mid-beat:** accept 3 symbols, then pulse `rst` for 1 cycle, then send 4 fresh symbols.
  - Required: exactly one beat is emitted, containing only the fresh symbols; `beat_cnt`=1.
- **Source stalls:** toggle `in_valid` randomly with stalls across 100 beats, checking against a scoreboard.
  - Required: every `oval` pulse lasts one cycle and data order is preserved.
  - Required: with `beat_cnt` preset by running 65536 beats, `beat_cnt` wraps to 0.
- **Single column:** COLS=1 build, stream 3 symbols.
  - Required: three `oval`=1'b1 pulses, each two edges after its accept, with `odata` equal to the symbol.
